lcd_init_sequencer: RTL and testbench
=====================================

LCD_INIT_SEQUENCER -- requirements
Module: lcd_init_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 12000000, meaning the CLK frequency in Hz; CLK_HZ/1000 SHALL be an integer of at least 1.
REQ-002 The block SHALL have parameter RST_LOW_MS, default 100, meaning the LCD reset pulse width in ms.
REQ-003 The block SHALL have parameter RST_WAIT_MS, default 120, meaning the settle time in ms after reset release, before the first command.
REQ-004 Port CLK  input  1  system clock; all logic is on its rising edge.
REQ-005 Port RESET  input  1  synchronous active-high reset.
REQ-006 Port LCD_RST  output  1  panel reset pin, active-low.
REQ-007 Port TX_VALID  output  1  byte request to the SPI byte serializer.
REQ-008 Port TX_DC  output  1  data/command flag for TX_BYTE (0 = command, 1 = data).
REQ-009 Port TX_BYTE  output  8  byte to be serialized.
REQ-010 Port TX_READY  input  1  serializer can accept a byte this cycle.
REQ-011 Port HOST_VALID  input  1  host byte request, used after initialization.
REQ-012 Port HOST_DC  input  1  host data/command flag.
REQ-013 Port HOST_BYTE  input  8  host byte.
REQ-014 Port HOST_READY  output  1  host byte accepted this cycle.
REQ-015 Port INIT_DONE  output  1  initialization sequence complete.
REQ-016 Port LED  output  1  status LED; equals INIT_DONE.

Function
REQ-017 A transfer SHALL occur on a rising edge where TX_VALID=1 and TX_READY=1; while TX_VALID=1 and no transfer has occurred, TX_DC and TX_BYTE SHALL stay stable.
REQ-018 States SHALL be RST_LOW, RST_WAIT, ISSUE, DELAY and READY.
REQ-019 Init ROM entries {dc, byte, delay_ms} SHALL be: 0 {0,0x11,120}; 1 {0,0x3A,0}; 2 {1,0x55,0}; 3 {0,0x13,10}; 4 {0,0x29,10}. The 3-bit index SHALL run from 0 to 4 with no wrap.
REQ-020 The ms timebase SHALL be a prescaler counting 0..CLK_HZ/1000-1 that is cleared on every state entry; an N ms wait SHALL last exactly N*CLK_HZ/1000 cycles.
REQ-021 RST_LOW: LCD_RST=0 for RST_LOW_MS ms, then LCD_RST=1 and go to RST_WAIT.
REQ-022 RST_WAIT: LCD_RST=1 for RST_WAIT_MS ms, then index=0 and go to ISSUE.
REQ-023 ISSUE: TX_VALID=1 with the ROM entry at index. On transfer:
  - if delay_ms>0, go to DELAY;
  - else if index<4, index+1 and stay in ISSUE (TX_VALID may stay 1 for the next entry);
  - else go to READY.
REQ-024 DELAY: wait delay_ms ms, starting the cycle after the transfer. Then, if index<4, index+1 and go to ISSUE; else go to READY.
REQ-025 READY: INIT_DONE=1. TX_VALID=HOST_VALID, TX_DC=HOST_DC, TX_BYTE=HOST_BYTE and HOST_READY=TX_READY, all combinational pass-through. READY is terminal until RESET.
REQ-026 Outside READY, HOST_READY SHALL be 0 and host inputs SHALL be ignored, with no queuing.
REQ-027 TX_READY while TX_VALID=0 SHALL have no effect.
REQ-028 Outside ISSUE and READY, TX_VALID SHALL be 0.
REQ-029 Delay counters SHALL be wide enough for max(RST_LOW_MS, RST_WAIT_MS, 120) without overflow.

Reset
REQ-030 While RESET=1, the following SHALL hold from the next edge:
  - state=RST_LOW, index=0, prescaler=0, ms counter=0;
  - LCD_RST=0, TX_VALID=0, TX_DC=0, TX_BYTE=0x00;
  - HOST_READY=0, INIT_DONE=0, LED=0.
REQ-031 RESET asserted mid-sequence or mid-handshake SHALL abort with no partial state kept. The serializer SHALL share RESET so that no half-sent byte survives.
REQ-032 The RST_LOW timing SHALL start on the first edge with RESET=0.

Verification (CLK_HZ=4000, i.e. 4 cycles/ms; RST_LOW_MS=3, RST_WAIT_MS=2)
REQ-033 Release RESET, TX_READY=1 -> LCD_RST low for exactly 12 cycles, then high. TX_VALID first rises 8 cycles later with TX_DC=0, TX_BYTE=0x11.
REQ-034 Full init with TX_READY=1 -> bytes 0x11(c), 0x3A(c), 0x55(d), 0x13(c), 0x29(c) in order, with gaps of 480, 0, 0 and 40 cycles after 0x11, 0x3A, 0x55 and 0x13. INIT_DONE rises 40 cycles after 0x29.
REQ-035 Hold TX_READY=0 for 7 cycles in ISSUE -> TX_VALID stays 1 with constant TX_BYTE; exactly one transfer occurs when TX_READY rises.
REQ-036 HOST_VALID=1 before INIT_DONE -> HOST_READY=0 and no host byte appears on TX. After INIT_DONE, HOST_VALID=1, HOST_DC=1, HOST_BYTE=0xA5, TX_READY=1 -> same-cycle TX_VALID=1, TX_BYTE=0xA5, TX_DC=1, HOST_READY=1.
REQ-037 RESET pulsed for 1 cycle during the 0x11 delay -> LCD_RST=0 and TX_VALID=0 on the next edge; the full sequence restarts from RST_LOW with identical timing.
REQ-038 Default parameters -> LCD_RST low for exactly 1,200,000 cycles; the 0x11 delay lasts exactly 1,440,000 cycles.

Source files
------------

// File: rtl/lcd_init_sequencer.sv
// Panel power-up sequencer: reset pulse, settle wait, then a fixed command ROM with per-entry ms delays.
// After init, host bytes pass straight through to the SPI byte serializer.
module lcd_init_sequencer #(
  parameter int CLK_HZ      = 12000000,
  parameter int RST_LOW_MS  = 100,
  parameter int RST_WAIT_MS = 120
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       LCD_RST,
  output logic       TX_VALID,
  output logic       TX_DC,
  output logic [7:0] TX_BYTE,
  input  logic       TX_READY,
  input  logic       HOST_VALID,
  input  logic       HOST_DC,
  input  logic [7:0] HOST_BYTE,
  output logic       HOST_READY,
  output logic       INIT_DONE,
  output logic       LED
);

  localparam int CYC_PER_MS = CLK_HZ / 1000;
  localparam int MS_MAX_A   = (RST_LOW_MS > RST_WAIT_MS) ? RST_LOW_MS : RST_WAIT_MS;
  localparam int MS_MAX     = (MS_MAX_A > 120) ? MS_MAX_A : 120;
  localparam int PW         = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam int MW         = $clog2(MS_MAX + 1);
  localparam logic [2:0] LAST_IDX = 3'd4;

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_ISSUE,
    S_DELAY,
    S_READY
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [MW-1:0]   ms_q, ms_d;

  logic            rom_dc;
  logic [7:0]      rom_byte;
  logic [6:0]      rom_dly;
  logic [MW-1:0]   wait_ms;
  logic            tick;
  logic            wait_done;

  always_comb begin
    rom_dc   = 1'b0;
    rom_byte = 8'h00;
    rom_dly  = 7'd0;
    case (idx_q)
      3'd0: begin rom_dc = 1'b0; rom_byte = 8'h11; rom_dly = 7'd120; end
      3'd1: begin rom_dc = 1'b0; rom_byte = 8'h3A; rom_dly = 7'd0;   end
      3'd2: begin rom_dc = 1'b1; rom_byte = 8'h55; rom_dly = 7'd0;   end
      3'd3: begin rom_dc = 1'b0; rom_byte = 8'h13; rom_dly = 7'd10;  end
      3'd4: begin rom_dc = 1'b0; rom_byte = 8'h29; rom_dly = 7'd10;  end
      default: ;
    endcase
  end

  // Length of the wait owned by the current state; a zero-length wait finishes at once.
  always_comb begin
    wait_ms = '0;
    case (state_q)
      S_RST_LOW:  wait_ms = MW'(RST_LOW_MS);
      S_RST_WAIT: wait_ms = MW'(RST_WAIT_MS);
      S_DELAY:    wait_ms = MW'(rom_dly);
      default:    wait_ms = '0;
    endcase
  end

  assign tick      = (pre_q == PW'(CYC_PER_MS - 1));
  assign wait_done = (wait_ms == '0) || (tick && (ms_q == wait_ms - MW'(1)));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_RST_LOW;
      idx_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_RST_LOW:  if (wait_done) state_d = S_RST_WAIT;
      S_RST_WAIT: if (wait_done) begin
        state_d = S_ISSUE;
        idx_d   = '0;
      end
      S_ISSUE: if (TX_READY) begin
        if (rom_dly != 7'd0)      state_d = S_DELAY;
        else if (idx_q < LAST_IDX) idx_d  = idx_q + 3'd1;
        else                      state_d = S_READY;
      end
      S_DELAY: if (wait_done) begin
        if (idx_q < LAST_IDX) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_READY;
        end
      end
      S_READY: state_d = S_READY;
      default: state_d = S_RST_LOW;
    endcase

    // Timebase restarts on every state entry and idles where no wait is running.
    if ((state_d != state_q) || (state_q == S_ISSUE) || (state_q == S_READY)) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (tick) begin
      pre_d = '0;
      ms_d  = ms_q + MW'(1);
    end else begin
      pre_d = pre_q + PW'(1);
      ms_d  = ms_q;
    end
  end

  always_comb begin
    LCD_RST    = (state_q != S_RST_LOW);
    TX_VALID   = 1'b0;
    TX_DC      = 1'b0;
    TX_BYTE    = 8'h00;
    HOST_READY = 1'b0;
    INIT_DONE  = 1'b0;
    case (state_q)
      S_ISSUE: begin
        TX_VALID = 1'b1;
        TX_DC    = rom_dc;
        TX_BYTE  = rom_byte;
      end
      S_READY: begin
        TX_VALID   = HOST_VALID;
        TX_DC      = HOST_DC;
        TX_BYTE    = HOST_BYTE;
        HOST_READY = TX_READY;
        INIT_DONE  = 1'b1;
      end
      default: ;
    endcase
    LED = INIT_DONE;
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer at 4 cycles/ms, RST_LOW_MS=3, RST_WAIT_MS=2.
// Expected transfers are queued by stimulus; a negedge monitor pops and compares each handshake.
module tb_lcd_init_sequencer;

  logic       CLK;
  logic       RESET;
  logic       LCD_RST;
  logic       TX_VALID;
  logic       TX_DC;
  logic [7:0] TX_BYTE;
  logic       TX_READY;
  logic       HOST_VALID;
  logic       HOST_DC;
  logic [7:0] HOST_BYTE;
  logic       HOST_READY;
  logic       INIT_DONE;
  logic       LED;

  lcd_init_sequencer #(
    .CLK_HZ(4000),
    .RST_LOW_MS(3),
    .RST_WAIT_MS(2)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .LCD_RST(LCD_RST),
    .TX_VALID(TX_VALID),
    .TX_DC(TX_DC),
    .TX_BYTE(TX_BYTE),
    .TX_READY(TX_READY),
    .HOST_VALID(HOST_VALID),
    .HOST_DC(HOST_DC),
    .HOST_BYTE(HOST_BYTE),
    .HOST_READY(HOST_READY),
    .INIT_DONE(INIT_DONE),
    .LED(LED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       dc;
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   base   = 0;
  int   checks = 0;
  int   errors = 0;
  logic       pend_q = 1'b0;
  logic       pend_dc;
  logic [7:0] pend_b;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must match the head of the queue, including its edge number.
  always @(negedge CLK) begin
    if (RESET) begin
      pend_q <= 1'b0;
    end else begin
      if (pend_q) begin
        chk("hold_valid", int'(TX_VALID), 1);
        chk("hold_dc_byte", int'({TX_DC, TX_BYTE}), int'({pend_dc, pend_b}));
      end
      if (TX_VALID && TX_READY) begin
        if (sb.size() == 0) begin
          chk("unexpected_tx", int'({TX_DC, TX_BYTE}), 512);
        end else begin
          mon_e = sb.pop_front();
          chk("tx_dc", int'(TX_DC), int'(mon_e.dc));
          chk("tx_byte", int'(TX_BYTE), int'(mon_e.b));
          chk("tx_edge", cyc + 1 - base, mon_e.at);
        end
      end
      pend_q  <= TX_VALID && !TX_READY;
      pend_dc <= TX_DC;
      pend_b  <= TX_BYTE;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_init(input int s);
    sb.push_back('{1'b0, 8'h11, 21 + s});
    sb.push_back('{1'b0, 8'h3A, 502 + s});
    sb.push_back('{1'b1, 8'h55, 503 + s});
    sb.push_back('{1'b0, 8'h13, 504 + s});
    sb.push_back('{1'b0, 8'h29, 545 + s});
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    sb.delete();
    repeat (n) step();
    chk("rst_lcd_rst", int'(LCD_RST), 0);
    chk("rst_tx_valid", int'(TX_VALID), 0);
    chk("rst_tx_dc", int'(TX_DC), 0);
    chk("rst_tx_byte", int'(TX_BYTE), 0);
    chk("rst_host_ready", int'(HOST_READY), 0);
    chk("rst_init_done", int'(INIT_DONE), 0);
    chk("rst_led", int'(LED), 0);
    RESET = 1'b0;
    base  = cyc;
  endtask

  // Edge numbers are counted from the first edge with RESET low (edge 1).
  task automatic run_seq(input int stall_to, input int abort_at, input int shift);
    int r_rise = -1;
    int v_rise = -1;
    int d_edge = -1;
    int rel;
    for (int i = 0; i < 1000; i++) begin
      step();
      rel = cyc - base;
      if (r_rise < 0 && LCD_RST) r_rise = rel;
      if (v_rise < 0 && TX_VALID) v_rise = rel;
      if (rel == stall_to) TX_READY = 1'b1;
      if (rel == 20 || rel == 300) chk("host_ready_blocked", int'(HOST_READY), 0);
      if (rel == 24 && stall_to > 0) begin
        chk("stall_valid", int'(TX_VALID), 1);
        chk("stall_byte", int'(TX_BYTE), 'h11);
      end
      if (rel == 400) HOST_VALID = 1'b0;
      if (rel == abort_at) break;
      if (INIT_DONE) begin
        d_edge = rel;
        break;
      end
    end
    chk("lcd_rst_rise_edge", r_rise, 12);
    chk("tx_valid_rise_edge", v_rise, 20);
    if (abort_at == 0) begin
      chk("init_done_edge", d_edge, 585 + shift);
      chk("led_done", int'(LED), 1);
      chk("sb_drained", sb.size(), 0);
    end
  endtask

  initial begin
    RESET      = 1'b1;
    TX_READY   = 1'b1;
    HOST_VALID = 1'b1;
    HOST_DC    = 1'b1;
    HOST_BYTE  = 8'hEE;

    // Full init with serializer always ready, host noise ignored.
    do_reset(3);
    push_init(0);
    run_seq(0, 0, 0);

    // Host pass-through in READY.
    HOST_VALID = 1'b1;
    HOST_DC    = 1'b0;
    HOST_BYTE  = 8'h3C;
    TX_READY   = 1'b0;
    #1;
    chk("host_ready_follows_0", int'(HOST_READY), 0);
    chk("pass_valid_stall", int'(TX_VALID), 1);
    chk("pass_byte_stall", int'(TX_BYTE), 'h3C);
    step();
    TX_READY = 1'b1;
    sb.push_back('{1'b0, 8'h3C, cyc + 1 - base});
    #1;
    chk("host_ready_follows_1", int'(HOST_READY), 1);
    step();
    HOST_DC   = 1'b1;
    HOST_BYTE = 8'hA5;
    sb.push_back('{1'b1, 8'hA5, cyc + 1 - base});
    #1;
    chk("pass_valid", int'(TX_VALID), 1);
    chk("pass_byte", int'(TX_BYTE), 'hA5);
    chk("pass_dc", int'(TX_DC), 1);
    chk("pass_host_ready", int'(HOST_READY), 1);
    step();
    HOST_VALID = 1'b0;
    #1;
    chk("pass_valid_off", int'(TX_VALID), 0);
    chk("host_sb_drained", sb.size(), 0);
    step();

    // Serializer stalls the first command for 7 cycles.
    TX_READY   = 1'b0;
    HOST_VALID = 1'b1;
    HOST_BYTE  = 8'hEE;
    do_reset(2);
    push_init(7);
    run_seq(27, 0, 7);

    // Reset pulse inside the 0x11 delay, then an identical restart.
    TX_READY   = 1'b1;
    HOST_VALID = 1'b1;
    do_reset(2);
    push_init(0);
    run_seq(0, 100, 0);
    do_reset(1);
    push_init(0);
    run_seq(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
